// File: rtl/game_referee.sv
// Tic-tac-toe referee: captures a board, applies agent/player moves, and declares win or draw.
// Define GAME_REFEREE_REWARD_EN to add a registered signed reward output.
module game_referee #(
  parameter int         MAX_MOVES   = 9,
  parameter logic [1:0] AGENT_MARK  = 2'b01,
  parameter logic [1:0] PLAYER_MARK = 2'b10
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        training,
  input  logic [17:0] state_in,
  input  logic [3:0]  action_in,
  input  logic [15:0] counter_in,
  output logic [17:0] board,
  output logic        move_ready,
  output logic        illegal_move,
  output logic        game_over,
  output logic [1:0]  winner,
  output logic [3:0]  move_count
`ifdef GAME_REFEREE_REWARD_EN
  ,
  output logic signed [7:0] reward
`endif
);

  typedef enum logic [1:0] {IDLE, PLAY, CHECK, DONE} state_t;

  localparam logic [3:0] MAX_CNT = 4'(MAX_MOVES);

  state_t      state, state_d;
  logic [17:0] board_d;
  logic [3:0]  count_d;
  logic [1:0]  winner_d;
  logic        illegal_d;
  logic        legal;
  logic [1:0]  mark;
  logic        agent_line, player_line;
  logic        counter_unused;
`ifdef GAME_REFEREE_REWARD_EN
  logic signed [7:0] reward_d;
`endif

  // Only the parity of the move counter selects the mover.
  assign counter_unused = ^counter_in[15:1];

  function automatic logic has_line(input logic [17:0] b, input logic [1:0] m);
    logic [8:0] h;
    for (int i = 0; i < 9; i++) h[i] = (b[2*i +: 2] == m);
    return (h[0] & h[1] & h[2]) | (h[3] & h[4] & h[5]) | (h[6] & h[7] & h[8]) |
           (h[0] & h[3] & h[6]) | (h[1] & h[4] & h[7]) | (h[2] & h[5] & h[8]) |
           (h[0] & h[4] & h[8]) | (h[2] & h[4] & h[6]);
  endfunction

  assign move_ready  = (state == PLAY);
  assign game_over   = (state == DONE);
  assign mark        = counter_in[0] ? AGENT_MARK : PLAYER_MARK;
  assign agent_line  = has_line(board, AGENT_MARK);
  assign player_line = has_line(board, PLAYER_MARK);

  // Indices 9..15 match no cell, so they are never legal.
  always_comb begin
    legal = 1'b0;
    for (int i = 0; i < 9; i++)
      if (action_in == 4'(i)) legal = (board[2*i +: 2] == 2'b00);
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d   = state;
    board_d   = board;
    count_d   = move_count;
    winner_d  = winner;
    illegal_d = 1'b0;
`ifdef GAME_REFEREE_REWARD_EN
    reward_d  = 8'sd0;
`endif
    case (state)
      IDLE: if (training) begin
        board_d  = state_in;
        count_d  = 4'd0;
        winner_d = 2'b00;
        state_d  = PLAY;
      end
      PLAY: if (legal) begin
        for (int i = 0; i < 9; i++)
          if (action_in == 4'(i)) board_d[2*i +: 2] = mark;
        if (move_count != MAX_CNT) count_d = move_count + 4'd1;
        state_d = CHECK;
      end else begin
        illegal_d = 1'b1;
`ifdef GAME_REFEREE_REWARD_EN
        reward_d  = -8'sd5;
`endif
      end
      CHECK: begin
        // Agent line takes priority when a preloaded board completes both.
        if (agent_line)                winner_d = 2'b01;
        else if (player_line)          winner_d = 2'b10;
        else if (move_count == MAX_CNT) winner_d = 2'b11;
        state_d = (winner_d != 2'b00) ? DONE : PLAY;
`ifdef GAME_REFEREE_REWARD_EN
        case (winner_d)
          2'b01:   reward_d = 8'sd10;
          2'b10:   reward_d = -8'sd10;
          default: reward_d = 8'sd0;
        endcase
`endif
      end
      default: ;
    endcase
    if (state != IDLE && !training) begin
      state_d   = IDLE;
      board_d   = '0;
      count_d   = 4'd0;
      winner_d  = 2'b00;
      illegal_d = 1'b0;
`ifdef GAME_REFEREE_REWARD_EN
      reward_d  = 8'sd0;
`endif
    end
  end

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      board        <= '0;
      move_count   <= 4'd0;
      winner       <= 2'b00;
      illegal_move <= 1'b0;
`ifdef GAME_REFEREE_REWARD_EN
      reward       <= 8'sd0;
`endif
    end else begin
      state        <= state_d;
      board        <= board_d;
      move_count   <= count_d;
      winner       <= winner_d;
      illegal_move <= illegal_d;
`ifdef GAME_REFEREE_REWARD_EN
      reward       <= reward_d;
`endif
    end
  end

endmodule
